// File: rtl/sdram_pkg.sv
// SDRAM shared definitions: command encodings, default mode register,
// FSM state encoding and the command-bus payload layout.
package sdram_pkg;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned BA_W       = 2;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned TIMER_W    = 16;
  localparam int unsigned PEND_W     = 4;
  localparam int unsigned INIT_CNT_W = 8;

  // {CSn, RASn, CASn, WEn}
  localparam logic [CMD_W-1:0] CMD_DESEL = 4'b1111;
  localparam logic [CMD_W-1:0] CMD_NOP   = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE   = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_REF   = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS   = 4'b0000;

  // CAS latency 3, sequential, burst length 8
  localparam logic [ADDR_W-1:0] MODE_REG_DEFAULT = 12'h033;

  // ADDR[10] selects all banks on PRECHARGE
  localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = 12'h400;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_TRP,
    S_REF,
    S_TRFC,
    S_MRS,
    S_TMRD,
    S_IDLE,
    S_AREF,
    S_ARFC
  } sdramState_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
  } sdramBus_t;

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter with a registered one-cycle done pulse.
// Ports:
//   iCLK     clock
//   iLoad    load iLoadVal (also clears done); held high by the owner during reset
//   iLoadVal cycles to count
//   oDone    pulses one cycle, iLoadVal cycles after the load edge
module sdram_wait_timer #(
  parameter int unsigned pWIDTH = 16
) (
  input  logic              iCLK,
  input  logic              iLoad,
  input  logic [pWIDTH-1:0] iLoadVal,
  output logic              oDone
);

  logic [pWIDTH-1:0] cnt;

  // Count down to zero; done fires on the 1 -> 0 step
  always_ff @(posedge iCLK) begin
    if (iLoad) begin
      cnt   <= iLoadVal;
      oDone <= 1'b0;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      oDone <= (cnt == pWIDTH'(1));
    end
  end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialisation and periodic AUTO REFRESH scheduler.
// Owns the SDRAM command pins until init completes, then requests refresh
// slots from the access controller through oREF_REQ / iREF_GNT.
// Ports:
//   iCLK, iRESET          memory clock, synchronous active-high reset
//   oSDRAM_*              SDRAM command pins (all registered)
//   oCMD_OWN              command mux select: this block drives the pins
//   oINIT_DONE            init sequence complete (sticky until reset)
//   oREF_REQ / iREF_GNT   refresh handshake with the access controller
//   oREF_BUSY             refresh command + tRFC window in progress
//   oREF_URGENT           pending refresh count reached pMAX_POSTPONE
// Wait timing assumes pTRP, pTRFC, pTMRD >= 2 and pPOWERUP_CYC >= 2.
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int unsigned       pPOWERUP_CYC    = 14300,
  parameter int unsigned       pTRP            = 3,
  parameter int unsigned       pTRFC           = 9,
  parameter int unsigned       pTMRD           = 2,
  parameter int unsigned       pINIT_REFRESHES = 8,
  parameter int unsigned       pREFRESH_CYC    = 1100,
  parameter int unsigned       pMAX_POSTPONE   = 8,
  parameter logic [ADDR_W-1:0] pMODE_REG       = MODE_REG_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRESET,
  output logic        oSDRAM_CKE,
  output logic        oSDRAM_CSn,
  output logic        oSDRAM_RASn,
  output logic        oSDRAM_CASn,
  output logic        oSDRAM_WEn,
  output logic [1:0]  oSDRAM_BA,
  output logic [11:0] oSDRAM_ADDR,
  output logic [1:0]  oSDRAM_DQM,
  output logic        oCMD_OWN,
  output logic        oINIT_DONE,
  output logic        oREF_REQ,
  input  logic        iREF_GNT,
  output logic        oREF_BUSY,
  output logic        oREF_URGENT
);

  sdramState_t             state, nextState;
  logic                    timerLoad_c;
  logic [TIMER_W-1:0]      timerLoadVal_c;
  logic                    timerDone;
  logic [INIT_CNT_W-1:0]   initRefCnt;
  logic [TIMER_W-1:0]      intervalCnt;
  logic [PEND_W-1:0]       pendCnt, pendNext_c;
  logic                    tick_c, grant_c;
  sdramBus_t               busQ, busNext_c;
  logic [1:0]              dqmNext_c;
  logic                    initDoneNext_c, busyNext_c, ownNext_c, reqNext_c, urgentNext_c;

  assign grant_c = oREF_REQ & iREF_GNT;
  assign tick_c  = oINIT_DONE && (intervalCnt == TIMER_W'(pREFRESH_CYC - 1));

  // Shared wait timer; reset preloads the power-up wait so cycle 0 starts counting
  always_comb begin
    timerLoad_c    = 1'b1;
    timerLoadVal_c = '0;
    if (iRESET) begin
      timerLoadVal_c = TIMER_W'(pPOWERUP_CYC);
    end else begin
      case (nextState)
        S_PRE:         timerLoadVal_c = TIMER_W'(pTRP - 1);
        S_REF, S_AREF: timerLoadVal_c = TIMER_W'(pTRFC - 1);
        S_MRS:         timerLoadVal_c = TIMER_W'(pTMRD - 1);
        default:       timerLoad_c    = 1'b0;
      endcase
    end
  end

  sdram_wait_timer #(
    .pWIDTH (TIMER_W)
  ) uWaitTimer (
    .iCLK     (iCLK),
    .iLoad    (timerLoad_c),
    .iLoadVal (timerLoadVal_c),
    .oDone    (timerDone)
  );

  // State register
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= S_PWRUP;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      S_PWRUP: if (timerDone) nextState = S_PRE;
      S_PRE:   nextState = S_TRP;
      S_TRP:   if (timerDone) nextState = S_REF;
      S_REF:   nextState = S_TRFC;
      S_TRFC: begin
        if (timerDone) begin
          nextState = (initRefCnt >= INIT_CNT_W'(pINIT_REFRESHES)) ? S_MRS : S_REF;
        end
      end
      S_MRS:   nextState = S_TMRD;
      S_TMRD:  if (timerDone) nextState = S_IDLE;
      S_IDLE:  if (grant_c) nextState = S_AREF;
      S_AREF:  nextState = S_ARFC;
      S_ARFC:  if (timerDone) nextState = S_IDLE;
      default: nextState = S_PWRUP;
    endcase
  end

  // Saturating pending count; a tick and a grant together cancel out
  always_comb begin
    pendNext_c = pendCnt;
    if (tick_c && !grant_c) begin
      if (pendCnt != '1) begin
        pendNext_c = pendCnt + 1'b1;
      end
    end else if (grant_c && !tick_c) begin
      pendNext_c = pendCnt - 1'b1;
    end
  end

  // Init refresh counter, free-running refresh interval and pending count
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      initRefCnt  <= '0;
      intervalCnt <= '0;
      pendCnt     <= '0;
    end else begin
      if (state == S_REF) begin
        initRefCnt <= initRefCnt + 1'b1;
      end
      if (!oINIT_DONE || tick_c) begin
        intervalCnt <= '0;
      end else begin
        intervalCnt <= intervalCnt + 1'b1;
      end
      pendCnt <= pendNext_c;
    end
  end

  // Output decode from the upcoming state so pins change with the state
  always_comb begin
    busNext_c      = '{cmd: CMD_NOP, ba: '0, addr: '0};
    initDoneNext_c = 1'b0;
    busyNext_c     = 1'b0;
    case (nextState)
      S_PRE:   busNext_c = '{cmd: CMD_PRE, ba: '0, addr: ADDR_PRE_ALL};
      S_REF:   busNext_c.cmd = CMD_REF;
      S_MRS:   busNext_c = '{cmd: CMD_MRS, ba: '0, addr: pMODE_REG};
      S_IDLE:  initDoneNext_c = 1'b1;
      S_AREF: begin
        busNext_c.cmd  = CMD_REF;
        initDoneNext_c = 1'b1;
        busyNext_c     = 1'b1;
      end
      S_ARFC: begin
        initDoneNext_c = 1'b1;
        busyNext_c     = 1'b1;
      end
      default: ;
    endcase
    dqmNext_c    = initDoneNext_c ? 2'b00 : 2'b11;
    ownNext_c    = !initDoneNext_c || busyNext_c;
    reqNext_c    = (pendNext_c != '0) && (nextState == S_IDLE);
    urgentNext_c = (pendNext_c >= PEND_W'(pMAX_POSTPONE));
  end

  // Output registers
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      busQ        <= '{cmd: CMD_DESEL, ba: '0, addr: '0};
      oSDRAM_CKE  <= 1'b0;
      oSDRAM_DQM  <= 2'b11;
      oCMD_OWN    <= 1'b1;
      oINIT_DONE  <= 1'b0;
      oREF_REQ    <= 1'b0;
      oREF_BUSY   <= 1'b0;
      oREF_URGENT <= 1'b0;
    end else begin
      busQ        <= busNext_c;
      oSDRAM_CKE  <= 1'b1;
      oSDRAM_DQM  <= dqmNext_c;
      oCMD_OWN    <= ownNext_c;
      oINIT_DONE  <= initDoneNext_c;
      oREF_REQ    <= reqNext_c;
      oREF_BUSY   <= busyNext_c;
      oREF_URGENT <= urgentNext_c;
    end
  end

  assign {oSDRAM_CSn, oSDRAM_RASn, oSDRAM_CASn, oSDRAM_WEn} = busQ.cmd;
  assign oSDRAM_BA   = busQ.ba;
  assign oSDRAM_ADDR = busQ.addr;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed self-checking bench for sdram_init_refresh (reduced timing).
module tb_sdram_init_refresh;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  // {CKE, CMD[3:0], BA[1:0], ADDR[11:0], DQM[1:0], OWN, DONE, REQ, BUSY, URG}
  localparam logic [25:0] RESET_VEC =
    {1'b0, 4'b1111, 2'b00, 12'h000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic        wMEM_CLK;
  logic        iRESET;
  logic        iREF_GNT;
  logic        oSDRAM_CKE, oSDRAM_CSn, oSDRAM_RASn, oSDRAM_CASn, oSDRAM_WEn;
  logic [1:0]  oSDRAM_BA;
  logic [11:0] oSDRAM_ADDR;
  logic [1:0]  oSDRAM_DQM;
  logic        oCMD_OWN, oINIT_DONE, oREF_REQ, oREF_BUSY, oREF_URGENT;
  logic [25:0] obs;
  logic [25:0] exp;

  int nChecks = 0;
  int nFails  = 0;

  sdram_init_refresh #(
    .pPOWERUP_CYC    (20),
    .pTRP            (3),
    .pTRFC           (9),
    .pTMRD           (2),
    .pINIT_REFRESHES (2),
    .pREFRESH_CYC    (50),
    .pMAX_POSTPONE   (3),
    .pMODE_REG       (12'h033)
  ) dut (
    .iCLK        (wMEM_CLK),
    .iRESET      (iRESET),
    .oSDRAM_CKE  (oSDRAM_CKE),
    .oSDRAM_CSn  (oSDRAM_CSn),
    .oSDRAM_RASn (oSDRAM_RASn),
    .oSDRAM_CASn (oSDRAM_CASn),
    .oSDRAM_WEn  (oSDRAM_WEn),
    .oSDRAM_BA   (oSDRAM_BA),
    .oSDRAM_ADDR (oSDRAM_ADDR),
    .oSDRAM_DQM  (oSDRAM_DQM),
    .oCMD_OWN    (oCMD_OWN),
    .oINIT_DONE  (oINIT_DONE),
    .oREF_REQ    (oREF_REQ),
    .iREF_GNT    (iREF_GNT),
    .oREF_BUSY   (oREF_BUSY),
    .oREF_URGENT (oREF_URGENT)
  );

  initial wMEM_CLK = 1'b0;
  always #5 wMEM_CLK = ~wMEM_CLK;

  assign obs = {oSDRAM_CKE, oSDRAM_CSn, oSDRAM_RASn, oSDRAM_CASn, oSDRAM_WEn,
                oSDRAM_BA, oSDRAM_ADDR, oSDRAM_DQM,
                oCMD_OWN, oINIT_DONE, oREF_REQ, oREF_BUSY, oREF_URGENT};

  function automatic logic [25:0] mk(input logic [3:0] cmd, input logic [11:0] addr,
                                     input logic done, input logic busy,
                                     input logic req, input logic urg);
    logic [1:0] dqm;
    logic       own;
    dqm = done ? 2'b00 : 2'b11;
    own = !done || busy;
    return {1'b1, cmd, 2'b00, addr, dqm, own, done, req, busy, urg};
  endfunction

  // Init schedule: PRE@20, REF@23,32, MRS@41, done from 43
  function automatic logic [25:0] expInit(input int k);
    logic [3:0]  cmd;
    logic [11:0] addr;
    cmd  = NOP;
    addr = 12'h000;
    if (k == 20) begin
      cmd  = PRE;
      addr = 12'h400;
    end else if (k == 23 || k == 32) begin
      cmd = AREF;
    end else if (k == 41) begin
      cmd  = MRS;
      addr = 12'h033;
    end
    return mk(cmd, addr, k >= 43, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic step();
    @(posedge wMEM_CLK);
    #1;
  endtask

  task automatic test_reset();
    iRESET   = 1'b1;
    iREF_GNT = 1'b0;
    repeat (3) step();
    nChecks++;
    if (obs !== RESET_VEC) begin
      nFails++;
      $display("FAIL reset_vals: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_init_sequence();
    iRESET = 1'b0;
    for (int k = 0; k <= 43; k++) begin
      step();
      exp = expInit(k);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL init_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  // No grants: REQ after first tick (93), URGENT from third tick (193),
  // URGENT must stay through ticks 16 and 17 (saturation, no wrap)
  task automatic test_idle_no_grant();
    for (int k = 44; k <= 893; k++) begin
      step();
      exp = mk(NOP, 12'h000, 1'b1, 1'b0, k >= 93, k >= 193);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL idle_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  // Reset from idle, then one-cycle reset at cycle 30 of init, then replay
  // with the grant held high throughout init
  task automatic test_reset_mid_init();
    iRESET = 1'b1;
    step();
    nChecks++;
    if (obs !== RESET_VEC) begin
      nFails++;
      $display("FAIL idle_reset: got %h expected %h", obs, RESET_VEC);
    end
    iRESET = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      step();
      exp = expInit(k);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL pre_reset_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
    iRESET = 1'b1;
    step();
    nChecks++;
    if (obs !== RESET_VEC) begin
      nFails++;
      $display("FAIL mid_reset: got %h expected %h", obs, RESET_VEC);
    end
    iRESET   = 1'b0;
    iREF_GNT = 1'b1;
    for (int k = 0; k <= 43; k++) begin
      step();
      exp = expInit(k);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL replay_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
    iREF_GNT = 1'b0;
  endtask

  // One pending; grant at 93; grant held during busy and after is ignored
  task automatic test_single_grant();
    for (int k = 44; k <= 93; k++) begin
      step();
      exp = mk(NOP, 12'h000, 1'b1, 1'b0, k >= 93, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL wait_req_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
    iREF_GNT = 1'b1;
    for (int k = 94; k <= 143; k++) begin
      step();
      if (k == 94)
        exp = mk(AREF, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (k <= 102)
        exp = mk(NOP, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
      else
        exp = mk(NOP, 12'h000, 1'b1, 1'b0, k >= 143, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL grant1_cyc%0d: got %h expected %h", k, obs, exp);
      end
      if (k == 110) iREF_GNT = 1'b0;
    end
  endtask

  // Grant on the tick cycle at pending=2 leaves 2; two more grants drain
  // it; the interval keeps its phase so the next tick lands on 293
  task automatic test_tick_grant();
    for (int k = 144; k <= 242; k++) begin
      step();
      exp = mk(NOP, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL pend_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
    for (int g = 0; g < 3; g++) begin
      iREF_GNT = 1'b1;
      step();
      iREF_GNT = 1'b0;
      exp = mk(AREF, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL tg_ref%0d: got %h expected %h", g, obs, exp);
      end
      for (int b = 1; b < 9; b++) begin
        step();
        exp = mk(NOP, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        nChecks++;
        if (obs !== exp) begin
          nFails++;
          $display("FAIL tg_busy%0d_%0d: got %h expected %h", g, b, obs, exp);
        end
      end
      step();
      exp = mk(NOP, 12'h000, 1'b1, 1'b0, g < 2, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL tg_after%0d: got %h expected %h", g, obs, exp);
      end
    end
    for (int k = 273; k <= 293; k++) begin
      step();
      exp = mk(NOP, 12'h000, 1'b1, 1'b0, k >= 293, 1'b0);
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("FAIL tg_tick_cyc%0d: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  initial begin
    iRESET   = 1'b1;
    iREF_GNT = 1'b0;
    test_reset();
    test_init_sequence();
    test_idle_no_grant();
    test_reset_mid_init();
    test_single_grant();
    test_tick_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
